// File: rtl/sv_handover_arbiter_if.sv
// Handshake bundle between the base-station handover FSMs (master) and the
// server-side handover arbiter (slave).
interface sv_handover_arbiter_if;
    logic [2:0] bs_req;
    logic [5:0] bs_target;
    logic [2:0] tgt_ack;
    logic [2:0] bs_grant;
    logic [2:0] tgt_notify;
    logic [1:0] tgt_src;
    logic [2:0] bs_done;
    logic [2:0] bs_fail;
    logic [2:0] bs_reject;

    modport master (
        output bs_req, bs_target, tgt_ack,
        input  bs_grant, tgt_notify, tgt_src, bs_done, bs_fail, bs_reject
    );

    modport slave (
        input  bs_req, bs_target, tgt_ack,
        output bs_grant, tgt_notify, tgt_src, bs_done, bs_fail, bs_reject
    );
endinterface

// File: rtl/sv_handover_arbiter.sv
// Round-robin arbiter serializing handovers between three base stations, with
// target acknowledge under timeout and commit to the server routing registers.
module sv_handover_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    sv_handover_arbiter_if.slave    ho,
    output logic [1:0]              sv_source,
    output logic [1:0]              sv_target,
    output logic                    sv_update,
    output logic                    ho_busy,
    output logic [7:0]              ho_count
);
    typedef enum logic [2:0] {StIdle, StGrant, StWaitAck, StDone, StFail} state_e;

    state_e     state_q, state_d;
    logic [1:0] src_q, src_d, tgt_q, tgt_d, rr_ptr_q, rr_ptr_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] grant_q, grant_d, notify_q, notify_d;
    logic [2:0] done_q, done_d, fail_q, fail_d, reject_q, reject_d;
    logic [1:0] tgt_src_q, tgt_src_d, sv_source_q, sv_source_d, sv_target_q, sv_target_d;
    logic       sv_update_q, sv_update_d, busy_q, busy_d;
    logic [7:0] count_q, count_d;

    logic [1:0] req_tgt [3];
    logic [2:0] valid, invalid;
    logic       found;
    logic [1:0] win;
    logic [2:0] cand;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        onehot = 3'b001 << idx;
    endfunction

    for (genvar n = 0; n < 3; n++) begin : g_tgt
        assign req_tgt[n] = ho.bs_target[2*n +: 2];
    end

    // A request is invalid when it names no target or itself.
    always_comb begin
        valid   = '0;
        invalid = '0;
        for (int n = 0; n < 3; n++) begin
            valid[n]   = ho.bs_req[n] && (req_tgt[n] != 2'd3) && (req_tgt[n] != 2'(n));
            invalid[n] = ho.bs_req[n] && !valid[n];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && valid[cand[1:0]]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        tgt_d       = tgt_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        grant_d     = '0;
        done_d      = '0;
        fail_d      = '0;
        reject_d    = '0;
        sv_update_d = 1'b0;
        sv_source_d = sv_source_q;
        sv_target_d = sv_target_q;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                reject_d = invalid;
                if (found) begin
                    src_d    = win;
                    tgt_d    = req_tgt[win];
                    rr_ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    grant_d  = onehot(win);
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                timer_d = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                // Ack wins over abort and timeout sampled in the same cycle.
                if (ho.tgt_ack[tgt_q]) begin
                    state_d     = StDone;
                    done_d      = onehot(src_q);
                    sv_update_d = 1'b1;
                    sv_source_d = src_q;
                    sv_target_d = tgt_q;
                    if (count_q != 8'd255) count_d = count_q + 8'd1;
                end else if (!ho.bs_req[src_q] || timer_q == 8'(TIMEOUT - 1)) begin
                    state_d = StFail;
                    fail_d  = onehot(src_q);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StDone, StFail: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        if (state_d == StGrant || state_d == StWaitAck) begin
            notify_d  = onehot(tgt_d);
            tgt_src_d = src_d;
        end else begin
            notify_d  = '0;
            tgt_src_d = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            src_q       <= '0;
            tgt_q       <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            notify_q    <= '0;
            done_q      <= '0;
            fail_q      <= '0;
            reject_q    <= '0;
            tgt_src_q   <= 2'd3;
            sv_source_q <= 2'd3;
            sv_target_q <= 2'd3;
            sv_update_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            tgt_q       <= tgt_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            notify_q    <= notify_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            reject_q    <= reject_d;
            tgt_src_q   <= tgt_src_d;
            sv_source_q <= sv_source_d;
            sv_target_q <= sv_target_d;
            sv_update_q <= sv_update_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign ho.bs_grant   = grant_q;
    assign ho.tgt_notify = notify_q;
    assign ho.tgt_src    = tgt_src_q;
    assign ho.bs_done    = done_q;
    assign ho.bs_fail    = fail_q;
    assign ho.bs_reject  = reject_q;
    assign sv_source     = sv_source_q;
    assign sv_target     = sv_target_q;
    assign sv_update     = sv_update_q;
    assign ho_busy       = busy_q;
    assign ho_count      = count_q;
endmodule

// File: tb/tb_sv_handover_arbiter.sv
// Directed bench for sv_handover_arbiter (TIMEOUT = 8); cycle 0 is the cycle a
// request is first presented in IDLE.
module tb_sv_handover_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sv_source, sv_target;
    logic       sv_update, ho_busy;
    logic [7:0] ho_count;
    int         n_checks = 0;
    int         n_pass = 0;

    sv_handover_arbiter_if bus ();

    sv_handover_arbiter #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ho        (bus.slave),
        .sv_source (sv_source),
        .sv_target (sv_target),
        .sv_update (sv_update),
        .ho_busy   (ho_busy),
        .ho_count  (ho_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.bs_req    = '0;
        bus.bs_target = 6'b111111;
        bus.tgt_ack   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"},  32'(bus.bs_grant), 0);
        check({tag, "_notify"}, 32'(bus.tgt_notify), 0);
        check({tag, "_tsrc"},   32'(bus.tgt_src), 3);
        check({tag, "_done"},   32'(bus.bs_done), 0);
        check({tag, "_fail"},   32'(bus.bs_fail), 0);
        check({tag, "_svsrc"},  32'(sv_source), 3);
        check({tag, "_svtgt"},  32'(sv_target), 3);
        check({tag, "_count"},  32'(ho_count), 0);
        check({tag, "_busy"},   32'(ho_busy), 0);
    endtask

    // Step until a grant appears, bounded; returns the grant vector seen.
    task automatic wait_grant(input string tag, output logic [2:0] g);
        logic seen;
        seen = 1'b0;
        g    = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.bs_grant != 3'b000) begin
                seen = 1'b1;
                g    = bus.bs_grant;
            end
        end
        check({tag, "_seen"}, 32'(seen), 1);
    endtask

    initial begin
        logic [2:0] g;
        int         dones;

        do_reset();
        check_reset_values("reset");
        check("reset_upd", 32'(sv_update), 0);

        // Single transaction: BS1 -> BS2, ack in cycle 4.
        bus.bs_req    = 3'b001;
        bus.bs_target = 6'b11_11_01;
        step();                                                   // cycle 1
        check("t1_grant", 32'(bus.bs_grant), 32'b001);
        check("t1_notify1", 32'(bus.tgt_notify), 32'b010);
        check("t1_tsrc1", 32'(bus.tgt_src), 0);
        check("t1_busy", 32'(ho_busy), 1);
        step();                                                   // cycle 2
        check("t1_grant_pulse", 32'(bus.bs_grant), 0);
        step();                                                   // cycle 3
        step();                                                   // cycle 4
        bus.tgt_ack = 3'b010;
        check("t1_notify4", 32'(bus.tgt_notify), 32'b010);
        check("t1_tsrc4", 32'(bus.tgt_src), 0);
        check("t1_done4", 32'(bus.bs_done), 0);
        step();                                                   // cycle 5
        bus.tgt_ack = 3'b000;
        bus.bs_req  = 3'b000;
        check("t1_done", 32'(bus.bs_done), 32'b001);
        check("t1_upd", 32'(sv_update), 1);
        check("t1_svsrc", 32'(sv_source), 0);
        check("t1_svtgt", 32'(sv_target), 1);
        check("t1_count", 32'(ho_count), 1);
        check("t1_notify5", 32'(bus.tgt_notify), 0);
        check("t1_tsrc5", 32'(bus.tgt_src), 3);
        step();                                                   // cycle 6
        check("t1_idle", 32'(ho_busy), 0);
        check("t1_upd_pulse", 32'(sv_update), 0);

        // Timeout: BS2 -> BS3, only non-target acks.
        bus.bs_req    = 3'b010;
        bus.bs_target = 6'b11_10_11;
        bus.tgt_ack   = 3'b011;
        for (int c = 1; c <= 9; c++) step();                      // cycle 9
        check("to_fail9", 32'(bus.bs_fail), 0);
        check("to_notify9", 32'(bus.tgt_notify), 32'b100);
        step();                                                   // cycle 10
        bus.bs_req  = 3'b000;
        bus.tgt_ack = 3'b000;
        check("to_fail", 32'(bus.bs_fail), 32'b010);
        check("to_done", 32'(bus.bs_done), 0);
        check("to_notify", 32'(bus.tgt_notify), 0);
        check("to_svsrc", 32'(sv_source), 0);
        check("to_svtgt", 32'(sv_target), 1);
        check("to_count", 32'(ho_count), 1);
        check("to_upd", 32'(sv_update), 0);
        step();

        // Late ack in the final WAIT_ACK cycle.
        bus.bs_req    = 3'b010;
        bus.bs_target = 6'b11_10_11;
        for (int c = 1; c <= 9; c++) step();                      // cycle 9
        bus.tgt_ack = 3'b100;
        check("la_tsrc9", 32'(bus.tgt_src), 1);
        step();                                                   // cycle 10
        bus.tgt_ack = 3'b000;
        bus.bs_req  = 3'b000;
        check("la_done", 32'(bus.bs_done), 32'b010);
        check("la_fail", 32'(bus.bs_fail), 0);
        check("la_svsrc", 32'(sv_source), 1);
        check("la_svtgt", 32'(sv_target), 2);
        check("la_count", 32'(ho_count), 2);
        step();

        // Abort: BS3 -> BS1, request dropped in cycle 3.
        bus.bs_req    = 3'b100;
        bus.bs_target = 6'b00_11_11;
        step();                                                   // cycle 1
        check("ab_grant", 32'(bus.bs_grant), 32'b100);
        step();                                                   // cycle 2
        step();                                                   // cycle 3
        bus.bs_req = 3'b000;
        check("ab_notify3", 32'(bus.tgt_notify), 32'b001);
        step();                                                   // cycle 4
        check("ab_fail", 32'(bus.bs_fail), 32'b100);
        check("ab_notify4", 32'(bus.tgt_notify), 0);
        check("ab_tsrc4", 32'(bus.tgt_src), 3);
        check("ab_count", 32'(ho_count), 2);
        step();

        // Reset while in WAIT_ACK drops the transaction silently.
        bus.bs_req    = 3'b001;
        bus.bs_target = 6'b11_11_10;
        step();
        step();
        step();                                                   // cycle 3
        check("rm_busy", 32'(ho_busy), 1);
        reset      = 1'b1;
        bus.bs_req = 3'b000;
        step();                                                   // cycle 4
        reset = 1'b0;
        check_reset_values("rm");
        step();
        check("rm_done_after", 32'(bus.bs_done), 0);
        check("rm_fail_after", 32'(bus.bs_fail), 0);

        // Round robin from rr_ptr = 0 with immediate acks.
        do_reset();
        bus.bs_req    = 3'b111;
        bus.bs_target = 6'b00_10_01;
        bus.tgt_ack   = 3'b111;
        wait_grant("rr1", g);
        check("rr_grant1", 32'(g), 32'b001);
        wait_grant("rr2", g);
        check("rr_grant2", 32'(g), 32'b010);
        wait_grant("rr3", g);
        check("rr_grant3", 32'(g), 32'b100);
        wait_grant("rr4", g);
        check("rr_grant4", 32'(g), 32'b001);
        bus.bs_req = 3'b000;
        step();
        step();
        step();
        bus.tgt_ack = 3'b000;
        check("rr_count", 32'(ho_count), 4);
        check("rr_idle", 32'(ho_busy), 0);

        // Invalid targets: BS2 names itself, BS3 names none.
        do_reset();
        bus.bs_req    = 3'b110;
        bus.bs_target = 6'b11_01_11;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("inv_reject", 32'(bus.bs_reject), 32'b110);
            check("inv_grant", 32'(bus.bs_grant), 0);
            check("inv_busy", 32'(ho_busy), 0);
        end
        bus.bs_req = 3'b000;
        step();
        check("inv_reject_clear", 32'(bus.bs_reject), 0);

        // Saturation: 256 successful handovers BS1 -> BS2.
        do_reset();
        dones         = 0;
        bus.bs_req    = 3'b001;
        bus.bs_target = 6'b11_11_01;
        bus.tgt_ack   = 3'b010;
        for (int c = 0; c < 1200 && dones < 256; c++) begin
            step();
            if (bus.bs_done != 3'b000) dones++;
            if (dones == 255 && bus.bs_done != 3'b000) check("sat_count255", 32'(ho_count), 255);
        end
        bus.bs_req  = 3'b000;
        bus.tgt_ack = 3'b000;
        check("sat_dones", 32'(dones), 256);
        step();
        step();
        check("sat_count", 32'(ho_count), 255);
        check("sat_idle", 32'(ho_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
